prog_sequencer: RTL and testbench

//  Sequences the single-cycle core through NUM_PROGS programs back-to-back.
//  Per program: drive start_addr, pulse start, wait for halt (with timeout), record cycle count.

---
 rtl/prog_sequencer.sv | 152 +++++++++++++++
 tb/tb_prog_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Runs NUM_PROGS programs on the core back-to-back: launch, mask stale halt, time the run, report, advance.
// Latency: go->start 1 cycle, halt->cyc_valid 1 cycle, cyc_valid->next start 1 cycle; abort returns to IDLE next cycle.
module prog_sequencer #(
    parameter int NUM_PROGS   = 3,
    parameter int PC_W        = 10,
    parameter int CNT_W       = 16,
    parameter int START_CYC   = 1,
    parameter int HALT_MASK   = 1,
    parameter int TIMEOUT_CYC = 4096,
    localparam int IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                      CLK,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic                      abort,
    input  logic [NUM_PROGS*PC_W-1:0] base_tbl,
    input  logic                      halt,
    output logic                      start,
    output logic [PC_W-1:0]           start_addr,
    output logic [IDX_W-1:0]          prog_idx,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_PROGS-1:0]      err_mask,
    output logic [CNT_W-1:0]          cyc_out,
    output logic                      cyc_valid
);

    localparam int PH_MAX = (START_CYC > HALT_MASK) ? START_CYC : HALT_MASK;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYC - 1);
    localparam logic [PH_W-1:0]  MASK_LAST  = PH_W'((HALT_MASK > 0) ? HALT_MASK - 1 : 0);
    localparam logic [31:0]      TO_LAST    = 32'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_MASK, S_RUN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [PH_W-1:0]   ph;
    logic [CNT_W-1:0]  cnt;
    logic [PC_W-1:0]   tbl [NUM_PROGS];
    logic [IDX_W-1:0]  nxt_idx;
    logic              cnt_last, last_prog;
    logic              halt_hit, tmo_hit, do_go, do_next;

    always_comb begin
        for (int i = 0; i < NUM_PROGS; i++) begin
            tbl[i] = base_tbl[i*PC_W +: PC_W];
        end
    end

    assign nxt_idx   = prog_idx + 1'b1;
    assign last_prog = (prog_idx == IDX_LAST);
    assign cnt_last  = (32'(cnt) == TO_LAST);

    // The cyc_valid cycle is the tail of RUN, so busy stays high between programs.
    always_comb begin
        state_nx = state;
        halt_hit = 1'b0;
        tmo_hit  = 1'b0;
        do_go    = 1'b0;
        do_next  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_nx = S_LAUNCH;
                    do_go    = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (ph == START_LAST) begin
                    state_nx = (HALT_MASK > 0) ? S_MASK : S_RUN;
                end
            end
            S_MASK: begin
                if (ph == MASK_LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (cyc_valid) begin
                    if (last_prog) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_LAUNCH;
                        do_next  = 1'b1;
                    end
                end else begin
                    halt_hit = halt;
                    tmo_hit  = !halt && cnt_last;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            halt_hit = 1'b0;
            tmo_hit  = 1'b0;
            do_go    = 1'b0;
            do_next  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ph         <= '0;
            cnt        <= '0;
            start_addr <= '0;
            prog_idx   <= '0;
            err_mask   <= '0;
            cyc_out    <= '0;
            cyc_valid  <= 1'b0;
        end else begin
            ph        <= (state_nx != state) ? '0 : ph + 1'b1;
            cyc_valid <= halt_hit || tmo_hit;

            if (state != S_RUN && state_nx == S_RUN) begin
                cnt <= '0;
            end else if (state == S_RUN && !cyc_valid && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            if (do_go) begin
                prog_idx   <= '0;
                err_mask   <= '0;
                start_addr <= tbl[0];
            end else if (do_next) begin
                prog_idx   <= nxt_idx;
                start_addr <= tbl[nxt_idx];
            end

            if (halt_hit) begin
                cyc_out <= cnt;
            end else if (tmo_hit) begin
                cyc_out            <= CNT_W'(TIMEOUT_CYC - 1);
                err_mask[prog_idx] <= 1'b1;
            end
        end
    end

    assign start = (state == S_LAUNCH);
    assign busy  = (state == S_LAUNCH) || (state == S_MASK) || (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: reset, full sequence, stale halt, timeout, abort, collisions.
module tb_prog_sequencer;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        go, abort, halt;
    logic [29:0] base_tbl;
    logic        start, busy, done, cyc_valid;
    logic [9:0]  start_addr;
    logic [1:0]  prog_idx;
    logic [2:0]  err_mask;
    logic [15:0] cyc_out;

    int n_tests = 0;
    int n_fail  = 0;

    prog_sequencer #(
        .NUM_PROGS(3), .PC_W(10), .CNT_W(16),
        .START_CYC(1), .HALT_MASK(1), .TIMEOUT_CYC(64)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .go(go), .abort(abort),
        .base_tbl(base_tbl), .halt(halt), .start(start),
        .start_addr(start_addr), .prog_idx(prog_idx), .busy(busy),
        .done(done), .err_mask(err_mask), .cyc_out(cyc_out),
        .cyc_valid(cyc_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input string tag);
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        check({tag, " go->start"}, 32'(start), 1);
    endtask

    task automatic expect_start(input string tag);
        @(negedge CLK);
        check({tag, " next start"}, 32'(start), 1);
    endtask

    task automatic expect_done(input string tag, input logic [2:0] exp_err);
        @(negedge CLK);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " busy@done"}, 32'(busy), 0);
        check({tag, " err@done"}, 32'(err_mask), 32'(exp_err));
    endtask

    // Called at the negedge where start is high. n = RUN count at which halt rises (<0: never).
    task automatic run_prog(input string tag, input int idx, input logic [9:0] addr, input int n,
                            input bit keep, input int go_k, input logic [2:0] exp_err);
        int k;
        int exp_cyc;
        exp_cyc = (n < 0) ? 63 : n;
        check({tag, " start_addr"}, 32'(start_addr), 32'(addr));
        check({tag, " prog_idx"}, 32'(prog_idx), 32'(idx));
        check({tag, " busy"}, 32'(busy), 1);
        k = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge CLK);
            k    = j;
            halt = (n >= 0) && ((j == n + 2) || (keep && j >= n + 2));
            go   = (j == go_k);
            if (cyc_valid) break;
        end
        go = 1'b0;
        if (!keep) halt = 1'b0;
        check({tag, " cyc_valid latency"}, 32'(k), 32'(exp_cyc + 3));
        check({tag, " cyc_out"}, 32'(cyc_out), 32'(exp_cyc));
        check({tag, " idx@valid"}, 32'(prog_idx), 32'(idx));
        check({tag, " err_mask"}, 32'(err_mask), 32'(exp_err));
    endtask

    task automatic abort_prog(input string tag, input int ka, input bit with_halt,
                              input logic [15:0] exp_cyc);
        for (int j = 1; j < ka; j++) @(negedge CLK);
        @(negedge CLK);
        abort = 1'b1;
        halt  = with_halt;
        @(negedge CLK);
        abort = 1'b0;
        halt  = 1'b0;
        check({tag, " start"}, 32'(start), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " cyc_valid"}, 32'(cyc_valid), 0);
        check({tag, " cyc_out kept"}, 32'(cyc_out), 32'(exp_cyc));
        @(negedge CLK);
        check({tag, " idle valid"}, 32'(cyc_valid), 0);
        check({tag, " idle start"}, 32'(start), 0);
    endtask

    initial begin
        reset_n  = 1'b1;
        go       = 1'b1;
        abort    = 1'b0;
        halt     = 1'b0;
        base_tbl = {10'd300, 10'd100, 10'd0};
        #1 reset_n = 1'b0;
        #2;
        check("rst start", 32'(start), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst cyc_valid", 32'(cyc_valid), 0);
        check("rst outs", {start_addr, prog_idx, err_mask, cyc_out}, 0);
        @(negedge CLK);
        @(negedge CLK);
        check("rst hold start", 32'(start), 0);
        go = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle start", 32'(start), 0);
        check("idle busy", 32'(busy), 0);

        // Basic three-program sequence
        launch("seq");
        run_prog("seq p0", 0, 10'd0, 20, 0, -1, 3'b000);
        expect_start("seq p1");
        run_prog("seq p1", 1, 10'd100, 35, 0, -1, 3'b000);
        expect_start("seq p2");
        run_prog("seq p2", 2, 10'd300, 50, 0, -1, 3'b000);
        expect_done("seq", 3'b000);
        check("seq start@done", 32'(start), 0);

        // Halt from program 0 still high through program 1 LAUNCH
        launch("stale");
        run_prog("stale p0", 0, 10'd0, 10, 1, -1, 3'b000);
        expect_start("stale p1");
        run_prog("stale p1", 1, 10'd100, 15, 0, -1, 3'b000);
        expect_start("stale p2");
        run_prog("stale p2", 2, 10'd300, 5, 0, -1, 3'b000);
        expect_done("stale", 3'b000);

        // Program 1 hangs
        launch("tmo");
        run_prog("tmo p0", 0, 10'd0, 3, 0, -1, 3'b000);
        expect_start("tmo p1");
        run_prog("tmo p1", 1, 10'd100, -1, 0, -1, 3'b010);
        expect_start("tmo p2");
        run_prog("tmo p2", 2, 10'd300, 7, 0, -1, 3'b010);
        expect_done("tmo", 3'b010);

        // Abort during program 1 RUN, then restart
        launch("abt");
        run_prog("abt p0", 0, 10'd0, 4, 0, -1, 3'b000);
        expect_start("abt p1");
        abort_prog("abt", 5, 1'b0, 16'd4);
        launch("abt re");
        run_prog("abt re p0", 0, 10'd0, 2, 0, -1, 3'b000);
        expect_start("abt re p1");
        run_prog("abt re p1", 1, 10'd100, 3, 0, -1, 3'b000);
        expect_start("abt re p2");
        run_prog("abt re p2", 2, 10'd300, 4, 0, -1, 3'b000);
        expect_done("abt re", 3'b000);

        // go while busy, halt together with timeout, abort together with halt
        launch("col");
        run_prog("col p0", 0, 10'd0, 63, 0, 10, 3'b000);
        expect_start("col p1");
        abort_prog("col abt+halt", 6, 1'b1, 16'd63);
        check("col err kept", 32'(err_mask), 0);

        // Reset mid-launch drops start without waiting for a clock
        launch("rst run");
        #1 reset_n = 1'b0;
        #1;
        check("rst run start", 32'(start), 0);
        check("rst run busy", 32'(busy), 0);
        check("rst run cyc_out", 32'(cyc_out), 0);
        @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);
        check("rst run idle", 32'(start), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
